// File: rtl/instr_encoder_loader_pkg.sv
// rtl/instr_encoder_loader_pkg.sv - shared RV32I encoding constants, request kinds and loader FSM states
package instr_encoder_loader_pkg;

    // Major opcodes
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    // funct3 values
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_WORD = 3'b010;
    localparam logic [2:0] F3_JALR = 3'b000;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;

    // funct7 values
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    // ALU op codes, identical to the core's ALUControl encoding
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;
    localparam logic [2:0] ALU_XOR = 3'b110;

    // Request kinds
    localparam logic [2:0] KIND_R      = 3'd0;
    localparam logic [2:0] KIND_I_ALU  = 3'd1;
    localparam logic [2:0] KIND_LOAD   = 3'd2;
    localparam logic [2:0] KIND_JALR   = 3'd3;
    localparam logic [2:0] KIND_STORE  = 3'd4;
    localparam logic [2:0] KIND_BRANCH = 3'd5;
    localparam logic [2:0] KIND_JAL    = 3'd6;
    localparam logic [2:0] KIND_LUI    = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/instr_encode_comb.sv
// rtl/instr_encode_comb.sv - combinational RV32I encoder for one symbolic request
//
// Ports: kind/alu_op/bne/rd/rs1/rs2/imm request fields in; word = encoded
// instruction, illegal = request outside the supported subset.
// Macro INSTR_ENC_IMM_CHECK_EN: also flags immediates that do not fit their
// field (or are misaligned); otherwise immediates are silently truncated.
import instr_encoder_loader_pkg::*;

module instr_encode_comb (
    input  logic [2:0]  kind,
    input  logic [2:0]  alu_op,
    input  logic        bne,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        illegal
);

    logic       op_err;
    logic       imm_err;
    logic [2:0] f3;
    logic [6:0] f7;

    always_comb begin
        word   = '0;
        op_err = 1'b0;
        f3     = F3_ADD;
        f7     = F7_BASE;
        case (kind)
            KIND_R: begin
                case (alu_op)
                    ALU_ADD: f3 = F3_ADD;
                    ALU_SUB: begin f3 = F3_ADD; f7 = F7_SUB; end
                    ALU_AND: f3 = F3_AND;
                    ALU_OR:  f3 = F3_OR;
                    ALU_SLT: f3 = F3_SLT;
                    ALU_XOR: f3 = F3_XOR;
                    default: op_err = 1'b1;
                endcase
                word = {f7, rs2, rs1, f3, rd, OP_R};
            end
            KIND_I_ALU: begin
                // No subi or andi in the core's decoder
                case (alu_op)
                    ALU_ADD: f3 = F3_ADD;
                    ALU_OR:  f3 = F3_OR;
                    ALU_SLT: f3 = F3_SLT;
                    ALU_XOR: f3 = F3_XOR;
                    default: op_err = 1'b1;
                endcase
                word = {imm[11:0], rs1, f3, rd, OP_I_ALU};
            end
            KIND_LOAD:   word = {imm[11:0], rs1, F3_WORD, rd, OP_LOAD};
            KIND_JALR:   word = {imm[11:0], rs1, F3_JALR, rd, OP_JALR};
            KIND_STORE:  word = {imm[11:5], rs2, rs1, F3_WORD, imm[4:0], OP_STORE};
            KIND_BRANCH: word = {imm[12], imm[10:5], rs2, rs1, (bne ? F3_BNE : F3_BEQ),
                                 imm[4:1], imm[11], OP_BRANCH};
            KIND_JAL:    word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
            default:     word = {imm[31:12], rd, OP_LUI};
        endcase
    end

`ifdef INSTR_ENC_IMM_CHECK_EN
    logic fit12, fit13, fit21;

    // A value fits an N-bit signed field when bits 31..N-1 are all equal
    assign fit12 = (&imm[31:11]) | ~(|imm[31:11]);
    assign fit13 = (&imm[31:12]) | ~(|imm[31:12]);
    assign fit21 = (&imm[31:20]) | ~(|imm[31:20]);

    always_comb begin
        imm_err = 1'b0;
        case (kind)
            KIND_I_ALU, KIND_LOAD, KIND_JALR, KIND_STORE: imm_err = ~fit12;
            KIND_BRANCH: imm_err = ~fit13 | imm[0];
            KIND_JAL:    imm_err = ~fit21 | imm[0];
            KIND_LUI:    imm_err = |imm[11:0];
            default:     imm_err = 1'b0;
        endcase
    end
`else
    logic unused_imm0;

    assign imm_err     = 1'b0;
    assign unused_imm0 = imm[0];
`endif

    assign illegal = op_err | imm_err;

endmodule

// File: rtl/instr_encoder_loader.sv
// rtl/instr_encoder_loader.sv - streams symbolic requests into encoded words written to instruction memory
//
// Ports: clk, rst_n (async active-low); start/finish session pulses;
// req_valid/req_ready handshake with req_kind/req_alu_op/req_bne/req_rd/
// req_rs1/req_rs2/req_imm fields; imem_we/imem_addr/imem_wdata write port;
// err_valid pulse for dropped illegal requests; count of words written in
// this session; done when the session has closed.
// Macro INSTR_ENC_IMM_CHECK_EN enables immediate range checking in the encoder.
import instr_encoder_loader_pkg::*;

module instr_encoder_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          DEPTH     = 256
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         finish,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [2:0]                   req_kind,
    input  logic [2:0]                   req_alu_op,
    input  logic                         req_bne,
    input  logic [4:0]                   req_rd,
    input  logic [4:0]                   req_rs1,
    input  logic [4:0]                   req_rs2,
    input  logic [31:0]                  req_imm,
    output logic                         imem_we,
    output logic [31:0]                  imem_addr,
    output logic [31:0]                  imem_wdata,
    output logic                         err_valid,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         done
);

    localparam int            CW       = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] LAST_C   = CW'(DEPTH - 1);

    state_t      state, state_nx;
    logic [31:0] enc_word;
    logic        enc_illegal;
    logic        accept;
    logic        wr_accept;

    instr_encode_comb u_encode (
        .kind    (req_kind),
        .alu_op  (req_alu_op),
        .bne     (req_bne),
        .rd      (req_rd),
        .rs1     (req_rs1),
        .rs2     (req_rs2),
        .imm     (req_imm),
        .word    (enc_word),
        .illegal (enc_illegal)
    );

    assign req_ready = (state == ST_LOAD) && (count < DEPTH_C);
    // A request arriving with start belongs to the session being discarded
    assign accept    = req_valid && req_ready && !start;
    assign wr_accept = accept && !enc_illegal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (start) begin
            state_nx = ST_LOAD;
        end else begin
            case (state)
                ST_LOAD: if (finish || (wr_accept && count == LAST_C)) state_nx = ST_DRAIN;
                ST_DRAIN: state_nx = ST_DONE;
                default:  state_nx = state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_we    <= 1'b0;
            imem_addr  <= BASE_ADDR;
            imem_wdata <= '0;
            err_valid  <= 1'b0;
            count      <= '0;
            done       <= 1'b0;
        end else if (start) begin
            imem_we    <= 1'b0;
            imem_addr  <= BASE_ADDR;
            err_valid  <= 1'b0;
            count      <= '0;
            done       <= 1'b0;
        end else begin
            imem_we   <= wr_accept;
            err_valid <= accept && enc_illegal;
            done      <= (state_nx == ST_DONE);
            if (wr_accept) begin
                imem_wdata <= enc_word;
                count      <= count + 1'b1;
            end
            // Address shows the current write's location and steps once it retires
            if (imem_we) imem_addr <= imem_addr + 32'd4;
        end
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb/tb_instr_encoder_loader.sv - directed self-checking bench for instr_encoder_loader
`timescale 1ns/1ps
module tb_instr_encoder_loader;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        finish = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_kind = '0;
    logic [2:0]  req_alu_op = '0;
    logic        req_bne = 1'b0;
    logic [4:0]  req_rd = '0;
    logic [4:0]  req_rs1 = '0;
    logic [4:0]  req_rs2 = '0;
    logic [31:0] req_imm = '0;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        err_valid;
    logic [2:0]  count;
    logic        done;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    instr_encoder_loader #(.BASE_ADDR(32'h0000_0000), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .finish     (finish),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_kind   (req_kind),
        .req_alu_op (req_alu_op),
        .req_bne    (req_bne),
        .req_rd     (req_rd),
        .req_rs1    (req_rs1),
        .req_rs2    (req_rs2),
        .req_imm    (req_imm),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .err_valid  (err_valid),
        .count      (count),
        .done       (done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [2:0] k, input logic [2:0] op, input logic b,
                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [31:0] imm);
        req_valid  = 1'b1;
        req_kind   = k;
        req_alu_op = op;
        req_bne    = b;
        req_rd     = rd;
        req_rs1    = rs1;
        req_rs2    = rs2;
        req_imm    = imm;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check("rst_ready", req_ready, 0);
        check("rst_we", imem_we, 0);
        check("rst_err", err_valid, 0);
        check("rst_done", done, 0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_wdata", imem_wdata, 32'h0);
        check("rst_count", count, 0);
        rst_n = 1'b1;
        tick();
        check("idle_ready", req_ready, 0);

        // addi x1, x0, 5
        pulse_start();
        check("start_ready", req_ready, 1);
        req(3'd1, 3'b000, 0, 5'd1, 5'd0, 5'd0, 32'd5);
        tick();
        req_valid = 1'b0;
        check("addi_we", imem_we, 1);
        check("addi_addr", imem_addr, 32'h0);
        check("addi_wdata", imem_wdata, 32'h0050_0093);
        check("addi_count", count, 1);
        tick();
        check("idle_we", imem_we, 0);
        check("addr_step", imem_addr, 32'h4);

        // add / sub back to back, then illegal requests, then early finish
        pulse_start();
        check("restart_addr", imem_addr, 32'h0);
        check("restart_count", count, 0);
        req(3'd0, 3'b000, 0, 5'd3, 5'd1, 5'd2, 32'd0);
        tick();
        check("add_we", imem_we, 1);
        check("add_addr", imem_addr, 32'h0);
        check("add_wdata", imem_wdata, 32'h0020_81B3);
        req(3'd0, 3'b001, 0, 5'd3, 5'd1, 5'd2, 32'd0);
        tick();
        check("sub_we", imem_we, 1);
        check("sub_addr", imem_addr, 32'h4);
        check("sub_wdata", imem_wdata, 32'h4020_81B3);
        check("sub_count", count, 2);
        req(3'd1, 3'b001, 0, 5'd1, 5'd1, 5'd0, 32'd1);
        tick();
        check("isub_err", err_valid, 1);
        check("isub_we", imem_we, 0);
        check("isub_count", count, 2);
        req(3'd0, 3'b111, 0, 5'd1, 5'd1, 5'd1, 32'd0);
        tick();
        check("r111_err", err_valid, 1);
        check("r111_we", imem_we, 0);
        req_valid = 1'b0;
        tick();
        check("err_pulse", err_valid, 0);
        finish = 1'b1;
        tick();
        finish = 1'b0;
        check("drain_ready", req_ready, 0);
        check("drain_done", done, 0);
        tick();
        check("fin_done", done, 1);
        check("fin_count", count, 2);

        // lw, sw, lui, beq fill DEPTH=4, fifth request refused
        pulse_start();
        check("s3_done", done, 0);
        req(3'd2, 3'b000, 0, 5'd5, 5'd2, 5'd0, 32'd8);
        tick();
        check("lw_wdata", imem_wdata, 32'h0081_2283);
        check("lw_addr", imem_addr, 32'h0);
        req(3'd4, 3'b000, 0, 5'd0, 5'd2, 5'd5, 32'd12);
        tick();
        check("sw_wdata", imem_wdata, 32'h0051_2623);
        check("sw_addr", imem_addr, 32'h4);
        req(3'd7, 3'b000, 0, 5'd4, 5'd0, 5'd0, 32'h1234_5000);
        tick();
        check("lui_wdata", imem_wdata, 32'h1234_5237);
        check("lui_addr", imem_addr, 32'h8);
        check("lui_ready", req_ready, 1);
        req(3'd5, 3'b000, 0, 5'd0, 5'd1, 5'd2, -32'sd8);
        tick();
        check("beq_we", imem_we, 1);
        check("beq_wdata", imem_wdata, 32'hFE20_8CE3);
        check("beq_addr", imem_addr, 32'hC);
        check("full_count", count, 4);
        check("full_ready", req_ready, 0);
        check("full_done0", done, 0);
        req(3'd6, 3'b000, 0, 5'd1, 5'd0, 5'd0, 32'd16);
        tick();
        check("fifth_we", imem_we, 0);
        check("fifth_count", count, 4);
        check("full_done", done, 1);
        req_valid = 1'b0;

        // jal, then the immediate-range case
        pulse_start();
        check("done_restart_ready", req_ready, 1);
        req(3'd6, 3'b000, 0, 5'd1, 5'd0, 5'd0, 32'd16);
        tick();
        check("jal_wdata", imem_wdata, 32'h0100_00EF);
        check("jal_addr", imem_addr, 32'h0);
        req(3'd1, 3'b000, 0, 5'd1, 5'd0, 5'd0, 32'd4096);
        tick();
        req_valid = 1'b0;
`ifdef INSTR_ENC_IMM_CHECK_EN
        check("big_imm_err", err_valid, 1);
        check("big_imm_we", imem_we, 0);
        check("big_imm_count", count, 1);
`else
        check("big_imm_err", err_valid, 0);
        check("big_imm_we", imem_we, 1);
        check("big_imm_wdata", imem_wdata, 32'h0000_0093);
        check("big_imm_count", count, 2);
`endif

        // start discards a pending write and any request in its cycle
        req(3'd1, 3'b000, 0, 5'd1, 5'd0, 5'd0, 32'd5);
        tick();
        req_valid = 1'b0;
        check("pend_we", imem_we, 1);
        pulse_start();
        check("discard_we", imem_we, 0);
        check("discard_addr", imem_addr, 32'h0);
        check("discard_count", count, 0);
        req(3'd1, 3'b000, 0, 5'd1, 5'd0, 5'd0, 32'd5);
        start = 1'b1;
        tick();
        start = 1'b0;
        req_valid = 1'b0;
        check("start_req_we", imem_we, 0);
        check("start_req_count", count, 0);
        start = 1'b1;
        finish = 1'b1;
        tick();
        start = 1'b0;
        finish = 1'b0;
        check("start_wins_ready", req_ready, 1);
        check("start_wins_done", done, 0);

        // asynchronous reset during a write
        req(3'd1, 3'b000, 0, 5'd1, 5'd0, 5'd0, 32'd5);
        tick();
        req_valid = 1'b0;
        check("pre_rst_we", imem_we, 1);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_we", imem_we, 0);
        check("async_rst_count", count, 0);
        check("async_rst_ready", req_ready, 0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
